rule_stream_arbiter: RTL
========================

Name: rule_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_IN independent 32-bit rule streams into one 32-bit rule stream. The inputs are typically the outputs of several rule depackers.
- The output feeds the shared rule consumer (rule-match reduction / result FIFO) of the SME.
- A grant is held from the first beat of a packet until its eop beat is accepted, so rule lists from different packets never interleave.
- A registered output stage and a packet counter provide timing isolation and debug visibility.

Parameters:
- NUM_IN, 4, number of requesting streams (2..16).
- DATA_WIDTH, 32, rule data width per beat.
- EMPTY_WIDTH, 2, width of the empty field.
- IDX_WIDTH, $clog2(NUM_IN), width of the grant index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_rule_sop  in  NUM_IN  per-input start-of-packet.
- in_rule_eop  in  NUM_IN  per-input end-of-packet.
- in_rule_valid  in  NUM_IN  per-input valid.
- in_rule_data  in  NUM_IN*DATA_WIDTH  flattened data; input i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_rule_empty  in  NUM_IN*EMPTY_WIDTH  flattened empty.
- in_rule_ready  out  NUM_IN  per-input ready.
- out_rule_sop  out  1  registered sop.
- out_rule_eop  out  1  registered eop.
- out_rule_valid  out  1  registered valid.
- out_rule_data  out  DATA_WIDTH  registered data.
- out_rule_empty  out  EMPTY_WIDTH  registered empty.
- out_rule_ready  in  1  downstream ready.
- grant_idx  out  IDX_WIDTH  currently/last granted input.
- busy  out  1  high while state is LOCKED.
- pkt_cnt  out  32  number of eop beats accepted from inputs; wraps at 2^32.

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state = IDLE, rr_ptr = 0, grant_idx = 0, busy = 0, pkt_cnt = 0, out_rule_valid/sop/eop = 0, out_rule_data = 0, out_rule_empty = 0, in_rule_ready = 0.
- Handshake: valid/ready, Avalon-ST style. A beat transfers on a cycle where valid && ready are both high.
- Output stage ready: out_free = !out_rule_valid || out_rule_ready.
- IDLE state:
  - in_rule_ready is all zero.
  - If any in_rule_valid is set, select the first valid input searching upward from rr_ptr, wrapping at NUM_IN. Load grant_idx with it, set state = LOCKED.
  - No beat is accepted in the arbitration cycle.
- LOCKED state:
  - in_rule_ready[grant_idx] = out_free (combinational). All other ready bits are 0.
  - On an accepted input beat, load the output registers with that input's data/sop/eop/empty and set out_rule_valid = 1.
  - Otherwise, if out_rule_ready is high, clear out_rule_valid.
  - When the accepted beat has eop = 1: pkt_cnt++, rr_ptr = (grant_idx + 1) mod NUM_IN, state = IDLE.
- Arbitration ignores sop: the first granted beat is forwarded even without sop, and the grant lasts until eop.
- Latency: input valid in IDLE -> out_rule_valid 2 cycles later (1 grant cycle + 1 register). Steady-state throughput is 1 beat/cycle within a packet. There is 1 idle cycle between packets.
- Back-to-back: a single-beat packet (sop & eop) returns to IDLE immediately. The next arbitration starts on the following cycle.
- Backpressure: while out_rule_ready = 0 and out_rule_valid = 1, output registers hold stable and the granted input is not accepted. An eop beat stalled this way keeps state LOCKED.
- Granted input deasserting valid mid-packet: grant is held indefinitely (no timeout). Other requesters wait.
- Non-granted inputs are never accepted and never see ready.
- Reset mid-packet: the packet is truncated, the output is cleared, and no partial eop is generated.
- Output registers drain normally after returning to IDLE: a pending output beat still waits for out_rule_ready.

Test Plan:
- Single requester: input 2 sends a 3-beat packet (0x11, 0x22, 0x33; eop on 0x33; out_rule_ready = 1) -> output the same 3 beats starting 2 cycles after the first valid; sop on 0x11, eop on 0x33; pkt_cnt = 1; grant_idx = 2.
- Fairness: all 4 inputs hold continuous 2-beat packets -> grant order 0, 1, 2, 3, 0, 1; no interleaving; pkt_cnt = 6 after 6 packets.
- Backpressure: out_rule_ready low for 5 cycles mid-packet -> output data stable, in_rule_ready[g] = 0 during the stall, no beat lost or duplicated.
- Mid-packet starvation: input 1 drops valid for 10 cycles after beat 1 while input 3 is requesting -> grant stays 1, input 3 is not served until input 1's eop is accepted.
- Single-beat packets: inputs 0 and 1 each send sop & eop beats 0xA0, 0xB0 -> outputs 0xA0 then 0xB0, each with sop = eop = 1, one bubble between them.
- Reset at beat 2 of a 4-beat packet -> next cycle all outputs are 0, rr_ptr = 0; a fresh request on input 3 is granted normally.

Source files
------------

// File: rtl/rule_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_IN rule streams into one registered stream.
// A grant is held from the first granted beat until that input's eop beat is accepted.
module rule_stream_arbiter #(
    parameter int NUM_IN      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int EMPTY_WIDTH = 2,
    parameter int IDX_WIDTH   = $clog2(NUM_IN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             in_rule_sop,
    input  logic [NUM_IN-1:0]             in_rule_eop,
    input  logic [NUM_IN-1:0]             in_rule_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_rule_data,
    input  logic [NUM_IN*EMPTY_WIDTH-1:0] in_rule_empty,
    output logic [NUM_IN-1:0]             in_rule_ready,
    output logic                          out_rule_sop,
    output logic                          out_rule_eop,
    output logic                          out_rule_valid,
    output logic [DATA_WIDTH-1:0]         out_rule_data,
    output logic [EMPTY_WIDTH-1:0]        out_rule_empty,
    input  logic                          out_rule_ready,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic                          busy,
    output logic [31:0]                   pkt_cnt
);

    localparam int KW = IDX_WIDTH + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_rr_ptr, w_rr_nxt;
    logic [IDX_WIDTH-1:0]    r_grant, w_grant_nxt;
    logic [IDX_WIDTH-1:0]    w_sel;
    logic                    r_out_valid, r_out_sop, r_out_eop;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [EMPTY_WIDTH-1:0]  r_out_empty;
    logic [31:0]             r_pkt_cnt;
    logic                    w_out_free, w_locked, w_acc;
    logic [DATA_WIDTH-1:0]   w_data_arr  [NUM_IN];
    logic [EMPTY_WIDTH-1:0]  w_empty_arr [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign w_data_arr[g]  = in_rule_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_empty_arr[g] = in_rule_empty[g*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    assign w_out_free = !r_out_valid || out_rule_ready;
    // Gating with rst keeps every ready bit low during the reset cycle itself.
    assign w_locked   = (r_state == LOCKED) && !rst;
    assign w_acc      = w_locked && w_out_free && in_rule_valid[r_grant];

    always_comb begin
        in_rule_ready = '0;
        if (w_locked)
            in_rule_ready[r_grant] = w_out_free;
    end

    // First valid requester at or above rr_ptr, wrapping at NUM_IN.
    always_comb begin
        logic          w_found;
        logic [KW-1:0] w_k;
        w_found = 1'b0;
        w_sel   = '0;
        w_k     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_k = {1'b0, r_rr_ptr} + KW'(i);
            if (w_k >= KW'(NUM_IN))
                w_k = w_k - KW'(NUM_IN);
            if (!w_found && in_rule_valid[w_k[IDX_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_k[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|in_rule_valid) begin
                    w_state_nxt = LOCKED;
                    w_grant_nxt = w_sel;
                end
            end
            LOCKED: begin
                if (w_acc && in_rule_eop[r_grant]) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = (r_grant == IDX_WIDTH'(NUM_IN - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_pkt_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
            r_out_empty <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_sop   <= in_rule_sop[r_grant];
                r_out_eop   <= in_rule_eop[r_grant];
                r_out_data  <= w_data_arr[r_grant];
                r_out_empty <= w_empty_arr[r_grant];
                if (in_rule_eop[r_grant])
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end else if (out_rule_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_rule_valid = r_out_valid;
    assign out_rule_sop   = r_out_sop;
    assign out_rule_eop   = r_out_eop;
    assign out_rule_data  = r_out_data;
    assign out_rule_empty = r_out_empty;
    assign grant_idx      = r_grant;
    assign busy           = (r_state == LOCKED);
    assign pkt_cnt        = r_pkt_cnt;

endmodule
